// File: rtl/cia_frame_accumulator.sv
// cia_frame_accumulator: valid/ready frame accumulator built on a carry-increment adder
//   clk, rst                             clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last    operand beat stream
//   out_valid/out_ready                  frame result handshake
//   out_sum/out_ovf/out_count            frame total mod 2^N, carry-out seen, saturating beat count
module cia_var_size #(
  parameter int N   = 64,
  parameter int NGs = 7,
  parameter int GS1 = 8,
  parameter int GS2 = 8,
  parameter int GS3 = 9,
  parameter int GS4 = 9,
  parameter int GS5 = 10,
  parameter int GS6 = 10,
  parameter int GS7 = 10
) (
  input  logic [N:1] a,
  input  logic [N:1] b,
  input  logic       cin,
  output logic [N:1] s,
  output logic       cout
);
  localparam int GS [7] = '{GS1, GS2, GS3, GS4, GS5, GS6, GS7};
  function automatic int off(input int g);
    int t = 0;
    for (int i = 0; i < g; i++) t += GS[i];
    return t;
  endfunction
  logic [NGs:0] c;
  assign c[0] = cin;
  for (genvar g = 0; g < NGs; g++) begin : grp
    localparam int W = GS[g];
    localparam int O = off(g);
    logic [W:0] t;
    assign t = {1'b0, a[O+W:O+1]} + {1'b0, b[O+W:O+1]};
    // group sum is all ones exactly when every bit propagates, so the incoming carry ripples out
    assign s[O+W:O+1] = t[W-1:0] + W'(c[g]);
    assign c[g+1] = t[W] | (&t[W-1:0] & c[g]);
  end
  assign cout = c[NGs];
endmodule

module cia_frame_accumulator #(
  parameter int N     = 64,
  parameter int NGs   = 7,
  parameter int GS1   = 8,
  parameter int GS2   = 8,
  parameter int GS3   = 9,
  parameter int GS4   = 9,
  parameter int GS5   = 10,
  parameter int GS6   = 10,
  parameter int GS7   = 10,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:1]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N:1]       out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic {ACC, DONE} state_t;
  state_t           state_q, state_d;
  logic [N:1]       acc_q, acc_d, sum, add_a, add_b;
  logic             ovf_q, ovf_d, first_q, first_d, cout, accept;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign in_ready  = (state_q == ACC) || out_ready;
  assign accept    = in_valid && in_ready;
  assign add_a     = first_q ? {N{1'b0}} : acc_q;
  // gate the operand so an undriven bus never reaches the adder
  assign add_b     = in_valid ? in_data : {N{1'b0}};
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_count = cnt_q;
  cia_var_size #(
    .N(N), .NGs(NGs), .GS1(GS1), .GS2(GS2), .GS3(GS3), .GS4(GS4), .GS5(GS5), .GS6(GS6), .GS7(GS7)
  ) u_add (
    .a(add_a), .b(add_b), .cin(1'b0), .s(sum), .cout(cout)
  );
  always_comb begin
    acc_d   = accept ? sum : acc_q;
    ovf_d   = accept ? ((!first_q && ovf_q) | cout) : ovf_q;
    cnt_d   = !accept ? cnt_q : first_q ? CNT_W'(1) : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    first_d = accept ? in_last : first_q;
    state_d = (accept && in_last) ? DONE : (state_q == DONE && out_ready) ? ACC : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      first_q <= 1'b1;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cia_frame_accumulator.sv
// tb_cia_frame_accumulator: directed and randomized checks of the frame accumulator at N=8
module tb_cia_frame_accumulator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:1] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [8:1] out_sum;
  logic       out_ovf;
  logic [3:0] out_count;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct packed {logic [7:0] s; logic o; logic [3:0] c;} res_t;
  res_t exp_q[$];
  int   n_frames = 25;
  cia_frame_accumulator #(.N(8), .NGs(1), .GS1(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic send(input logic [7:0] d, input logic last);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (!in_ready) begin n_fail++; $display("FAIL send_timeout in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    n_checks++; if (out_sum !== 8'd0) begin n_fail++; $display("FAIL reset_sum got %0d want 0", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
    n_checks++; if (out_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", out_count); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_basic;
    out_ready = 1'b1;
    send(8'd3, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
    send(8'd4, 1'b0);
    send(8'd5, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", out_valid); end
    n_checks++; if (out_sum !== 8'd12) begin n_fail++; $display("FAIL basic_sum got %0d want 12", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", out_ovf); end
    n_checks++; if (out_count !== 4'd3) begin n_fail++; $display("FAIL basic_count got %0d want 3", out_count); end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consumed got %b want 0", out_valid); end
  endtask
  task automatic test_overflow;
    send(8'hF0, 1'b0);
    send(8'h20, 1'b1);
    n_checks++; if (out_sum !== 8'h10) begin n_fail++; $display("FAIL ovf_sum got %h want 10", out_sum); end
    n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", out_ovf); end
    n_checks++; if (out_count !== 4'd2) begin n_fail++; $display("FAIL ovf_count got %0d want 2", out_count); end
    send(8'd1, 1'b1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", out_valid); end
    n_checks++; if (out_sum !== 8'd1) begin n_fail++; $display("FAIL b2b_sum got %0d want 1", out_sum); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf got %b want 0", out_ovf); end
    n_checks++; if (out_count !== 4'd1) begin n_fail++; $display("FAIL b2b_count got %0d want 1", out_count); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_backpressure;
    send(8'd2, 1'b0);
    send(8'd3, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd7;
    in_last   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cyc %0d got %b want 0", i, in_ready); end
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_sum !== 8'd5 || out_count !== 4'd2)
        begin n_fail++; $display("FAIL bp_hold cyc %0d got v=%b s=%0d c=%0d want v=1 s=5 c=2", i, out_valid, out_sum, out_count); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 8'd7 || out_count !== 4'd1 || out_ovf !== 1'b0)
      begin n_fail++; $display("FAIL bp_next got v=%b s=%0d c=%0d o=%b want v=1 s=7 c=1 o=0", out_valid, out_sum, out_count, out_ovf); end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consumed got %b want 0", out_valid); end
  endtask
  task automatic test_saturation;
    for (int i = 0; i < 20; i++) send(8'd1, i == 19);
    n_checks++; if (out_sum !== 8'd20) begin n_fail++; $display("FAIL sat_sum got %0d want 20", out_sum); end
    n_checks++; if (out_count !== 4'd15) begin n_fail++; $display("FAIL sat_count got %0d want 15", out_count); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf got %b want 0", out_ovf); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset_midframe;
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_idle got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
    send(8'd9, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 8'd9 || out_count !== 4'd1 || out_ovf !== 1'b0)
      begin n_fail++; $display("FAIL rstmid_frame got v=%b s=%0d c=%0d o=%b want v=1 s=9 c=1 o=0", out_valid, out_sum, out_count, out_ovf); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_random;
    int got = 0;
    int cyc = 0;
    fork
      begin
        for (int f = 0; f < n_frames; f++) begin
          logic [7:0] d[$];
          res_t r;
          logic [8:0] t;
          int len = $urandom_range(1, 40);
          r = '0;
          for (int i = 0; i < len; i++) begin
            d.push_back(8'($urandom_range(0, 255)));
            t = {1'b0, r.s} + {1'b0, d[i]};
            r.s = t[7:0];
            r.o = r.o | t[8];
            r.c = (r.c == 4'd15) ? 4'd15 : r.c + 4'd1;
          end
          exp_q.push_back(r);
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
            send(d[i], i == len - 1);
          end
        end
      end
      begin
        while (got < n_frames && cyc < 20000) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_extra got s=%0d c=%0d want no result", out_sum, out_count);
            end else if ({out_sum, out_ovf, out_count} !== exp_q[0]) begin
              n_fail++; $display("FAIL rand_frame %0d got s=%0d o=%b c=%0d want s=%0d o=%b c=%0d",
                got, out_sum, out_ovf, out_count, exp_q[0].s, exp_q[0].o, exp_q[0].c);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
          end
          cyc++;
        end
      end
    join
    n_checks++; if (got != n_frames) begin n_fail++; $display("FAIL rand_count got %0d want %0d", got, n_frames); end
    out_ready = 1'b1;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_backpressure;
    test_saturation;
    test_reset_midframe;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
